arb_mux_nto1: RTL and testbench
===============================

// Module: arb_mux_nto1
// PURPOSE
//  Parametrised N-to-1 datapath mux with built-in arbitration and a registered, handshaked output.
//  Successor to the fixed 2:1/4:1 select muxes: select is no longer driven externally.
//  Internal round-robin (or fixed-priority) arbiter picks among valid sources each cycle.
//  Sits between multiple LC-3 bus sources (PC, MDR, ALU, MARMUX) and a single sink.
//  Adds stall/backpressure handling, unlike the combinational muxes.
// PARAMETERS
//  WIDTH     16  data width of every channel and of the output
//  CHANNELS  4   number of input channels, 2..16
//  RR_MODE   1   1 = round-robin arbitration; 0 = fixed priority, lowest index wins
// PORTS
//  Clk        in   1                  system clock; all state updates on rising edge
//  Reset_n    in   1                  synchronous, active-low reset
//  in_valid   in   CHANNELS           per-channel request valid
//  in_ready   out  CHANNELS           per-channel accept; at most one bit high per cycle
//  in_data    in   CHANNELS x WIDTH   per-channel data, packed [CHANNELS-1:0][WIDTH-1:0]
//  out_valid  out  1                  output register holds a word
//  out_ready  in   1                  sink accepts the word
//  out_data   out  WIDTH              registered mux output
//  out_chan   out  CW                 index of the channel that supplied out_data
//                                     CW = $clog2(CHANNELS)
// BEHAVIOUR
//  Reset (Reset_n == 0 at a rising edge):
//   - out_valid=0, out_data=0, out_chan=0, rr pointer=0.
//   - in_ready=0 during the reset cycle.
//   - Reset mid-transfer drops the held word; no in_ready pulse in that cycle.
//  Accept condition: load = ~out_valid | out_ready. This gives a single-stage pipe at full throughput.
//  Grant (combinational):
//   - RR_MODE=1: first valid channel searching from ptr upward, wrapping CHANNELS-1 -> 0.
//   - RR_MODE=0: lowest-index valid channel.
//   - in_ready[g] = load & any(in_valid); all other in_ready bits are 0.
//  Register update on transfer (load & any valid):
//   - out_data <= in_data[g], out_chan <= g, out_valid <= 1.
//   - ptr <= (g == CHANNELS-1) ? 0 : g+1.
//  Register update on load with no valid input:
//   - out_valid <= 0; out_data and out_chan hold; ptr holds.
//  Stall (out_valid & ~out_ready):
//   - out_data and out_chan are stable; all in_ready are 0; ptr holds.
//  Latency: a source transfer at edge k makes out_valid=1 after edge k; the output is a direct register.
//  Throughput: one word per cycle while out_ready=1.
//  Fairness:
//   - RR mode: with all channels continuously valid, grants cycle 0,1,..,N-1,0.
//   - RR mode: no channel waits more than CHANNELS-1 grants.
//  Simultaneous out_ready and a new grant in the same cycle: old word leaves and new word loads.
//   No bubble, no loss.
//  Only ptr, out_valid, out_data and out_chan are state; everything else is combinational.
// STRUCTURE
//  Shared package mux_pkg:
//   - function chan_w(n) returning $clog2(n), minimum 1.
//   - localparam MAX_CHANNELS=16.
//   - typedef logic [15:0] word_t.
//  Sub-module rr_arbiter #(N, RR_MODE), which contains ptr.
//   - Inputs: Clk, Reset_n, req[N], advance.
//   - Outputs: gnt_onehot[N], gnt_idx, any_req.
//   - Advances ptr only on advance.
//  The top level holds the data mux, the output register and the load logic.
//  Elaboration check: CHANNELS outside 2..16 raises $error.
// TESTING
//  1. Reset: drive Reset_n=0 with in_valid=4'hF.
//     -> out_valid=0, out_data=0, out_chan=0, in_ready=0.
//  2. Single source: in_valid=4'b0100, in_data[2]=16'hBEEF, out_ready=1.
//     -> in_ready=4'b0100; next cycle out_data=16'hBEEF, out_chan=2.
//  3. Round-robin: RR_MODE=1, in_valid=4'hF held, out_ready=1.
//     -> out_chan sequence 0,1,2,3,0,1 on consecutive cycles.
//  4. Fixed priority: RR_MODE=0, in_valid=4'b1010.
//     -> channel 1 granted every cycle; channel 3 starves.
//  5. Backpressure: out_ready=0 for 3 cycles while out_valid=1.
//     -> out_data and out_chan stable, in_ready=0.
//     -> Raise out_ready: next grant resumes at ptr with no word lost or duplicated.
//  6. Wrap and mid-op reset:
//     -> Grant channel 3: ptr wraps to 0 and the next grant is channel 0.
//     -> Assert Reset_n=0 while stalled: out_valid=0 next cycle and ptr=0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and helpers for the arbitrated N-to-1 mux and its arbiter.
package mux_pkg;
  localparam int unsigned MAX_CHANNELS = 16;

  typedef logic [15:0] word_t;

  function automatic int unsigned chan_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin or fixed-priority arbiter; owns the rotating search pointer.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter bit          RR_MODE = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [N-1:0]          req,
  input  logic                  advance,
  output logic [N-1:0]          gnt_onehot,
  output logic [chan_w(N)-1:0]  gnt_idx,
  output logic                  any_req
);
  localparam int unsigned CW = chan_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] ptr;

  // Search starts at ptr (or 0 in fixed-priority mode) and wraps past N-1.
  always_comb begin
    int unsigned c;
    gnt_idx    = '0;
    gnt_onehot = '0;
    any_req    = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      c = RR_MODE ? (int'(ptr) + i) : i;
      if (c >= N) c = c - N;
      if (!any_req && req[c]) begin
        any_req        = 1'b1;
        gnt_idx        = CW'(c);
        gnt_onehot[c]  = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
    end
  end
endmodule

// File: rtl/arb_mux_nto1.sv
// N-to-1 data mux with internal arbitration and a single registered, handshaked output stage.
module arb_mux_nto1
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  parameter bit          RR_MODE  = 1'b1
) (
  input  logic                               Clk,
  input  logic                               Reset_n,
  input  logic [CHANNELS-1:0]                in_valid,
  output logic [CHANNELS-1:0]                in_ready,
  input  logic [CHANNELS-1:0][WIDTH-1:0]     in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WIDTH-1:0]                   out_data,
  output logic [chan_w(CHANNELS)-1:0]        out_chan
);
  localparam int unsigned CW = chan_w(CHANNELS);

  if (CHANNELS < 2 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
    $error("arb_mux_nto1: CHANNELS must be in 2..16");
  end

  logic [CHANNELS-1:0] gnt_onehot;
  logic [CW-1:0]       gnt_idx;
  logic                any_req;
  logic                load;
  logic                xfer;

  assign load     = ~out_valid | out_ready;
  assign xfer     = Reset_n & load & any_req;
  // Gating with Reset_n keeps sources from seeing an accept that reset discards.
  assign in_ready = xfer ? gnt_onehot : '0;

  rr_arbiter #(
    .N       (CHANNELS),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .req        (in_valid),
    .advance    (xfer),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any_req    (any_req)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (load) begin
      out_valid <= any_req;
      if (any_req) begin
        out_data <= in_data[gnt_idx];
        out_chan <= gnt_idx;
      end
    end
  end
endmodule

// File: tb/tb_arb_mux_nto1.sv
// Scoreboard bench: round-robin and fixed-priority instances driven with the same stimulus.
module tb_arb_mux_nto1;
  import mux_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [3:0]           in_valid;
  logic [3:0][15:0]     in_data;
  logic                 out_ready;
  logic [3:0]           rdy_rr, rdy_fp;
  logic                 ov_rr, ov_fp;
  word_t                od_rr, od_fp;
  logic [1:0]           oc_rr, oc_fp;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arb_mux_nto1 #(.WIDTH(16), .CHANNELS(4), .RR_MODE(1'b1)) u_rr (
    .Clk(clk), .Reset_n(rst_n), .in_valid(in_valid), .in_ready(rdy_rr),
    .in_data(in_data), .out_valid(ov_rr), .out_ready(out_ready),
    .out_data(od_rr), .out_chan(oc_rr));

  arb_mux_nto1 #(.WIDTH(16), .CHANNELS(4), .RR_MODE(1'b0)) u_fp (
    .Clk(clk), .Reset_n(rst_n), .in_valid(in_valid), .in_ready(rdy_fp),
    .in_data(in_data), .out_valid(ov_fp), .out_ready(out_ready),
    .out_data(od_fp), .out_chan(oc_fp));

  // Reference model state: index 0 = round-robin instance, 1 = fixed priority.
  int          ptr_m [2];
  bit          ov_m  [2];
  bit          ld_m  [2];
  bit          xf_m  [2];
  int          g_m   [2];
  logic [17:0] q_rr [$];
  logic [17:0] q_fp [$];

  function automatic int grant(input logic [3:0] v, input int p, input bit rr);
    int c;
    for (int i = 0; i < 4; i++) begin
      c = rr ? (p + i) % 4 : i;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Grant prediction and in_ready check, mid-cycle.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      logic [3:0] exp_rdy;
      exp_rdy = '0;
      xf_m[m] = 1'b0;
      ld_m[m] = !ov_m[m] || out_ready;
      g_m[m]  = grant(in_valid, ptr_m[m], m == 0);
      if (rst_n && ld_m[m] && g_m[m] >= 0) begin
        xf_m[m] = 1'b1;
        exp_rdy[g_m[m]] = 1'b1;
      end
      if (m == 0) check("in_ready_rr", 32'(rdy_rr), 32'(exp_rdy));
      else        check("in_ready_fp", 32'(rdy_fp), 32'(exp_rdy));
    end
  end

  // Model register update at the edge; inputs are stable until #1 after it.
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        ptr_m[m] = 0;
        ov_m[m]  = 1'b0;
      end else begin
        if (xf_m[m]) begin
          if (m == 0) q_rr.push_back({2'(g_m[m]), in_data[g_m[m]]});
          else        q_fp.push_back({2'(g_m[m]), in_data[g_m[m]]});
          ptr_m[m] = (g_m[m] + 1) % 4;
        end
        if (ld_m[m]) ov_m[m] = xf_m[m];
      end
    end
    if (!rst_n) begin
      q_rr.delete();
      q_fp.delete();
    end
  end

  // Output monitor: compare presented words against the scoreboard queues.
  always @(negedge clk) begin
    check("out_valid_rr", 32'(ov_rr), 32'(q_rr.size() != 0));
    if (ov_rr && q_rr.size() != 0) begin
      check("out_word_rr", {14'd0, oc_rr, od_rr}, 32'(q_rr[0]));
      if (out_ready) void'(q_rr.pop_front());
    end
    check("out_valid_fp", 32'(ov_fp), 32'(q_fp.size() != 0));
    if (ov_fp && q_fp.size() != 0) begin
      check("out_word_fp", {14'd0, oc_fp, od_fp}, 32'(q_fp[0]));
      if (out_ready) void'(q_fp.pop_front());
    end
  end

  task automatic cycles(input int n, input logic [3:0] v, input logic rdy, input bit rnd_data);
    for (int i = 0; i < n; i++) begin
      in_valid  = v;
      out_ready = rdy;
      if (rnd_data)
        for (int c = 0; c < 4; c++) in_data[c] = 16'($urandom);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 4'hF; out_ready = 1'b1; in_data = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_valid", 32'(ov_rr), 0);
    check("rst_data",  32'(od_rr), 0);
    check("rst_chan",  32'(oc_rr), 0);
    check("rst_ready", 32'(rdy_rr), 0);
    rst_n = 1'b1;

    in_data[2] = 16'hBEEF;
    cycles(1, 4'b0100, 1'b1, 1'b0);
    check("single_data", 32'(od_rr), 32'h0000BEEF);
    check("single_chan", 32'(oc_rr), 2);

    cycles(8, 4'hF, 1'b1, 1'b1);      // rotating grants vs. fixed channel 0
    cycles(6, 4'b1010, 1'b1, 1'b1);   // channel 3 starves in fixed priority
    cycles(1, 4'hF, 1'b1, 1'b1);
    cycles(3, 4'hF, 1'b0, 1'b1);      // stall with held output
    cycles(4, 4'hF, 1'b1, 1'b1);

    for (int i = 0; i < 400; i++)
      cycles(1, 4'($urandom), ($urandom_range(0, 3) != 0), 1'b1);

    cycles(2, 4'hF, 1'b0, 1'b1);
    rst_n = 1'b0;
    cycles(1, 4'hF, 1'b0, 1'b1);
    rst_n = 1'b1;
    check("midrst_valid", 32'(ov_rr), 0);
    cycles(1, 4'hF, 1'b1, 1'b1);
    check("post_rst_chan", 32'(oc_rr), 0);
    for (int i = 0; i < 50; i++)
      cycles(1, 4'($urandom), 32'($urandom) % 2 == 0 ? 1'b0 : 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
